sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 28 ++
 rtl/sram_wait_counter.sv | 37 +++
 rtl/sram_arbiter.sv | 157 +++++++++++++++
 tb/tb_sram_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
// Shared types and constants for the SRAM arbiter slice.
//   state_t         : arbiter FSM states (IDLE / ACCESS / DONE)
//   WAIT_STATES_DEF : default number of SRAM access cycles per transfer
//   CNT_W           : width of the wait-state down-counter
//   pick_ldr()      : round-robin winner selection (1 = loader wins)
// ----------------------------------------------------------------------------
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int unsigned WAIT_STATES_DEF = 32'd2;
  localparam int unsigned CNT_W           = 32'd3;

  // On a tie the requester that was not granted last wins; a lone request
  // always wins.
  function automatic logic pick_ldr(input logic cpu_req,
                                    input logic ldr_req,
                                    input logic last_was_ldr);
    return ldr_req & (~cpu_req | ~last_was_ldr);
  endfunction

endpackage : sram_arb_pkg

// File: rtl/sram_wait_counter.sv
// ----------------------------------------------------------------------------
// sram_wait_counter
// Loadable down-counter that paces the SRAM access phase.
//   clk      : rising-edge clock
//   reset    : synchronous, active-high; clears the count
//   load     : load load_val (has priority over dec)
//   load_val : value loaded on load
//   dec      : decrement by one; the count holds at zero
//   zero     : count is zero
// ----------------------------------------------------------------------------
module sram_wait_counter
  import sram_arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count_r;

  // Count register: reset, load, or saturating decrement
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {CNT_W{1'b0}})) begin
      count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign zero = (count_r == {CNT_W{1'b0}});

endmodule : sram_wait_counter

// File: rtl/sram_arbiter.sv
// ----------------------------------------------------------------------------
// sram_arbiter
// Round-robin arbiter granting a single SRAM to a CPU port and a program
// loader port. One transfer = IDLE (grant) -> WAIT_STATES ACCESS cycles ->
// one DONE cycle carrying the ack pulse. WAIT_STATES must lie in 1..7.
//   Clk, Reset               : clock, synchronous active-high reset
//   cpu_req/we/addr/wdata    : CPU transfer request (req held until ack)
//   cpu_ack                  : one-cycle completion pulse for the CPU
//   ldr_req/we/addr/wdata    : loader transfer request, same semantics
//   ldr_ack                  : one-cycle completion pulse for the loader
//   rdata                    : read data, valid while the owner's ack is high
//   gnt_ldr                  : current/last transfer belongs to the loader
//   busy                     : a transfer is in progress
//   ADDR, Data_to_SRAM       : SRAM address and write data (latched)
//   OE, WE                   : active-high SRAM read / write enables
//   Data_from_SRAM           : SRAM read data
// All outputs are registered.
// ----------------------------------------------------------------------------
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WAIT_STATES_DEF
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [15:0] ldr_addr,
  input  logic [15:0] ldr_wdata,
  output logic        ldr_ack,
  output logic [15:0] rdata,
  output logic        gnt_ldr,
  output logic        busy,
  output logic [15:0] ADDR,
  output logic [15:0] Data_to_SRAM,
  output logic        OE,
  output logic        WE,
  input  logic [15:0] Data_from_SRAM
);

  // The counter starts one below the cycle count so that the cycle in which
  // it reads zero is the last ACCESS cycle.
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_STATES - 32'd1);

  state_t      state_r;
  logic        we_r;
  logic        grant_s;
  logic        pick_ldr_s;
  logic        dec_s;
  logic        cnt_zero_s;
  logic        sel_we_s;
  logic [15:0] sel_addr_s;
  logic [15:0] sel_wdata_s;

  // Arbitration decision and wait-counter control for this cycle
  always_comb begin
    grant_s    = 1'b0;
    pick_ldr_s = 1'b0;
    dec_s      = 1'b0;
    if (state_r == IDLE) begin
      grant_s    = cpu_req | ldr_req;
      // gnt_ldr still holds the owner of the previous transfer here
      pick_ldr_s = pick_ldr(cpu_req, ldr_req, gnt_ldr);
    end else begin
      dec_s = (state_r == ACCESS);
    end
  end

  // Steer the winner's transfer attributes toward the latches
  always_comb begin
    if (pick_ldr_s) begin
      sel_we_s    = ldr_we;
      sel_addr_s  = ldr_addr;
      sel_wdata_s = ldr_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr;
      sel_wdata_s = cpu_wdata;
    end
  end

  sram_wait_counter u_wait_counter (
    .clk      (Clk),
    .reset    (Reset),
    .load     (grant_s),
    .load_val (LOAD_VAL),
    .dec      (dec_s),
    .zero     (cnt_zero_s)
  );

  // Transfer sequencing FSM and every registered output
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r      <= IDLE;
      we_r         <= 1'b0;
      OE           <= 1'b0;
      WE           <= 1'b0;
      cpu_ack      <= 1'b0;
      ldr_ack      <= 1'b0;
      busy         <= 1'b0;
      ADDR         <= 16'h0000;
      Data_to_SRAM <= 16'h0000;
      rdata        <= 16'h0000;
      gnt_ldr      <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
          if (grant_s) begin
            state_r      <= ACCESS;
            busy         <= 1'b1;
            gnt_ldr      <= pick_ldr_s;
            we_r         <= sel_we_s;
            ADDR         <= sel_addr_s;
            Data_to_SRAM <= sel_wdata_s;
            // Enables are driven for the whole ACCESS phase
            OE           <= ~sel_we_s;
            WE           <= sel_we_s;
          end
        end
        ACCESS: begin
          if (cnt_zero_s) begin
            state_r <= DONE;
            OE      <= 1'b0;
            WE      <= 1'b0;
            if (!we_r) begin
              rdata <= Data_from_SRAM;
            end
            cpu_ack <= ~gnt_ldr;
            ldr_ack <= gnt_ldr;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          OE      <= 1'b0;
          WE      <= 1'b0;
          cpu_ack <= 1'b0;
          ldr_ack <= 1'b0;
        end
      endcase
    end
  end

endmodule : sram_arbiter

// File: tb/tb_sram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sram_arbiter
// Three arbiters (WAIT_STATES = 2, 1, 7) with independent stimulus. A
// directed vector table drives the WAIT_STATES=2 instance; latency,
// alternation and randomized traffic are checked against a transaction-level
// model built from the transfer timeline (grant at T, access T+1..T+WS,
// ack at T+WS+1).
// ----------------------------------------------------------------------------
module tb_sram_arbiter;

  function automatic int unsigned ws_of(input int g);
    if (g == 0) return 32'd2;
    else if (g == 1) return 32'd1;
    else return 32'd7;
  endfunction

  logic        clk;
  logic        reset;
  logic        cpu_req [3];
  logic        cpu_we  [3];
  logic [15:0] cpu_addr [3];
  logic [15:0] cpu_wdata [3];
  logic        cpu_ack [3];
  logic        ldr_req [3];
  logic        ldr_we  [3];
  logic [15:0] ldr_addr [3];
  logic [15:0] ldr_wdata [3];
  logic        ldr_ack [3];
  logic [15:0] rdata [3];
  logic        gnt_ldr [3];
  logic        busy [3];
  logic [15:0] addr [3];
  logic [15:0] dout [3];
  logic        oe [3];
  logic        we [3];
  logic [15:0] sram_rd [3];

  int n_cmp = 0;
  int n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sram_arbiter #(.WAIT_STATES(ws_of(g))) u_dut (
      .Clk            (clk),
      .Reset          (reset),
      .cpu_req        (cpu_req[g]),
      .cpu_we         (cpu_we[g]),
      .cpu_addr       (cpu_addr[g]),
      .cpu_wdata      (cpu_wdata[g]),
      .cpu_ack        (cpu_ack[g]),
      .ldr_req        (ldr_req[g]),
      .ldr_we         (ldr_we[g]),
      .ldr_addr       (ldr_addr[g]),
      .ldr_wdata      (ldr_wdata[g]),
      .ldr_ack        (ldr_ack[g]),
      .rdata          (rdata[g]),
      .gnt_ldr        (gnt_ldr[g]),
      .busy           (busy[g]),
      .ADDR           (addr[g]),
      .Data_to_SRAM   (dout[g]),
      .OE             (oe[g]),
      .WE             (we[g]),
      .Data_from_SRAM (sram_rd[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        cr;
    logic        cw;
    logic [15:0] ca;
    logic [15:0] cd;
    logic        lr;
    logic        lw;
    logic [15:0] la;
    logic [15:0] ld;
    logic [15:0] sd;
    logic        e_busy;
    logic        e_oe;
    logic        e_we;
    logic        e_cack;
    logic        e_lack;
    logic        e_gnt;
    logic [15:0] e_addr;
    logic [15:0] e_dout;
    logic [15:0] e_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input int rst, input int cr, input int cw, input int ca, input int cd,
                              input int lr, input int lw, input int la, input int ld, input int sd,
                              input int eb, input int eo, input int ew, input int eca, input int ela,
                              input int eg, input int ea, input int edo, input int er);
    vec_t v;
    v.rst = rst[0];   v.cr = cr[0];   v.cw = cw[0];   v.ca = ca[15:0];  v.cd = cd[15:0];
    v.lr = lr[0];     v.lw = lw[0];   v.la = la[15:0]; v.ld = ld[15:0]; v.sd = sd[15:0];
    v.e_busy = eb[0]; v.e_oe = eo[0]; v.e_we = ew[0]; v.e_cack = eca[0]; v.e_lack = ela[0];
    v.e_gnt = eg[0];  v.e_addr = ea[15:0]; v.e_dout = edo[15:0]; v.e_rdata = er[15:0];
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    for (int g = 0; g < 3; g++) begin
      cpu_req[g] = 1'b0;  cpu_we[g] = 1'b0;  cpu_addr[g] = 16'h0000;  cpu_wdata[g] = 16'h0000;
      ldr_req[g] = 1'b0;  ldr_we[g] = 1'b0;  ldr_addr[g] = 16'h0000;  ldr_wdata[g] = 16'h0000;
      sram_rd[g] = 16'h0000;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    zero_inputs();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Transaction-level reference run on all three instances
  task automatic run_model(input int ncyc, input bit hold_both);
    bit          act [3];
    int          t0 [3];
    bit          own [3];
    bit          mwe [3];
    bit          last [3];
    bit          cpend [3];
    bit          lpend [3];
    logic [15:0] maddr [3];
    logic [15:0] mdout [3];
    logic [15:0] mrd [3];
    bit          order [$];
    do_reset();
    for (int g = 0; g < 3; g++) begin
      act[g] = 1'b0;  t0[g] = 0;  own[g] = 1'b0;  mwe[g] = 1'b0;  last[g] = 1'b1;
      cpend[g] = 1'b0;  lpend[g] = 1'b0;
      maddr[g] = 16'h0000;  mdout[g] = 16'h0000;  mrd[g] = 16'h0000;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int g = 0; g < 3; g++) begin
        int ws;
        int k;
        bit acc;
        bit fin;
        string p;
        ws  = int'(ws_of(g));
        k   = c - t0[g];
        if (act[g] && k > ws + 1) act[g] = 1'b0;
        acc = act[g] && (k >= 1) && (k <= ws);
        fin = act[g] && (k == ws + 1);
        p = $sformatf("%s.ws%0d.c%0d", hold_both ? "alt" : "rnd", ws, c);
        chk1({p, ".busy"}, busy[g], act[g]);
        chk1({p, ".oe"}, oe[g], acc & ~mwe[g]);
        chk1({p, ".we"}, we[g], acc & mwe[g]);
        chk1({p, ".cpu_ack"}, cpu_ack[g], fin & ~own[g]);
        chk1({p, ".ldr_ack"}, ldr_ack[g], fin & own[g]);
        chk1({p, ".gnt_ldr"}, gnt_ldr[g], last[g]);
        chk16({p, ".addr"}, addr[g], maddr[g]);
        chk16({p, ".dout"}, dout[g], mdout[g]);
        chk16({p, ".rdata"}, rdata[g], mrd[g]);
        if (fin) begin
          if (own[g]) lpend[g] = 1'b0;
          else cpend[g] = 1'b0;
          if (g == 0) order.push_back(own[g]);
        end
        if (hold_both) begin
          cpu_req[g] = 1'b1;
          ldr_req[g] = 1'b1;
        end else begin
          if (!cpend[g]) cpend[g] = ($urandom_range(0, 2) == 0);
          if (!lpend[g]) lpend[g] = ($urandom_range(0, 2) == 0);
          cpu_req[g] = cpend[g];
          ldr_req[g] = lpend[g];
        end
        cpu_we[g]    = 1'($urandom_range(0, 1));
        ldr_we[g]    = 1'($urandom_range(0, 1));
        cpu_addr[g]  = 16'($urandom);
        cpu_wdata[g] = 16'($urandom);
        ldr_addr[g]  = 16'($urandom);
        ldr_wdata[g] = 16'($urandom);
        sram_rd[g]   = 16'($urandom);
        // A read samples SRAM data during its last access cycle
        if (acc && (k == ws) && !mwe[g]) mrd[g] = sram_rd[g];
        if (!act[g] && (cpu_req[g] || ldr_req[g])) begin
          if (cpu_req[g] && ldr_req[g]) own[g] = ~last[g];
          else own[g] = ldr_req[g];
          act[g]   = 1'b1;
          t0[g]    = c;
          last[g]  = own[g];
          mwe[g]   = own[g] ? ldr_we[g] : cpu_we[g];
          maddr[g] = own[g] ? ldr_addr[g] : cpu_addr[g];
          mdout[g] = own[g] ? ldr_wdata[g] : cpu_wdata[g];
        end
      end
      @(negedge clk);
    end
    if (hold_both) begin
      chki("alt.ack_count_ge3", (order.size() >= 3) ? 1 : 0, 1);
      if (order.size() >= 3) begin
        chk1("alt.first_owner_ldr", order[0], 1'b0);
        chk1("alt.second_owner_ldr", order[1], 1'b1);
        chk1("alt.third_owner_ldr", order[2], 1'b0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat [3];

    //        rst cr cw ca      cd      lr lw la      ld      sd       busy oe we cak lak gnt addr    dout    rdata
    // CPU read of 0x0010 returning 0xBEEF; request fields change mid-transfer
    tbl.push_back(mk(0, 1, 0, 'h0010, 'h0000, 0, 0, 'h0000, 'h0000, 'hBEEF, 0, 0, 0, 0, 0, 1, 'h0000, 'h0000, 'h0000));
    tbl.push_back(mk(0, 1, 0, 'hFFFF, 'hAAAA, 0, 0, 'h0000, 'h0000, 'hBEEF, 1, 1, 0, 0, 0, 0, 'h0010, 'h0000, 'h0000));
    tbl.push_back(mk(0, 1, 1, 'hFFFF, 'hAAAA, 0, 0, 'h0000, 'h0000, 'hBEEF, 1, 1, 0, 0, 0, 0, 'h0010, 'h0000, 'h0000));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 1, 0, 0, 1, 0, 0, 'h0010, 'h0000, 'hBEEF));
    // Loader write of 0x1234 to 0x0200; rdata must keep 0xBEEF
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 1, 1, 'h0200, 'h1234, 'h0000, 0, 0, 0, 0, 0, 0, 'h0010, 'h0000, 'hBEEF));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 1, 1, 'h0200, 'h5555, 'h9999, 1, 0, 1, 0, 0, 1, 'h0200, 'h1234, 'hBEEF));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 1, 0, 'h0300, 'h5555, 'h9999, 1, 0, 1, 0, 0, 1, 'h0200, 'h1234, 'hBEEF));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 1, 0, 0, 0, 1, 1, 'h0200, 'h1234, 'hBEEF));
    // Reset, then both ports request together: CPU first, loader 4 cycles later
    tbl.push_back(mk(1, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0, 0, 0, 0, 1, 'h0200, 'h1234, 'hBEEF));
    tbl.push_back(mk(0, 1, 0, 'h0011, 'h0000, 1, 1, 'h0222, 'h4321, 'h0A0A, 0, 0, 0, 0, 0, 1, 'h0000, 'h0000, 'h0000));
    tbl.push_back(mk(0, 1, 0, 'h0011, 'h0000, 1, 1, 'h0222, 'h4321, 'h0A0A, 1, 1, 0, 0, 0, 0, 'h0011, 'h0000, 'h0000));
    tbl.push_back(mk(0, 1, 0, 'h0011, 'h0000, 1, 1, 'h0222, 'h4321, 'h0A0A, 1, 1, 0, 0, 0, 0, 'h0011, 'h0000, 'h0000));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 1, 1, 'h0222, 'h4321, 'h0000, 1, 0, 0, 1, 0, 0, 'h0011, 'h0000, 'h0A0A));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 1, 1, 'h0222, 'h4321, 'h0000, 0, 0, 0, 0, 0, 0, 'h0011, 'h0000, 'h0A0A));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 1, 1, 'h0222, 'h4321, 'h0000, 1, 0, 1, 0, 0, 1, 'h0222, 'h4321, 'h0A0A));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 1, 1, 'h0222, 'h4321, 'h0000, 1, 0, 1, 0, 0, 1, 'h0222, 'h4321, 'h0A0A));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 1, 0, 0, 0, 1, 1, 'h0222, 'h4321, 'h0A0A));
    // CPU read aborted by reset in its second ACCESS cycle (loader also requesting)
    tbl.push_back(mk(0, 1, 0, 'h0033, 'h0000, 0, 0, 'h0000, 'h0000, 'h7777, 0, 0, 0, 0, 0, 1, 'h0222, 'h4321, 'h0A0A));
    tbl.push_back(mk(0, 1, 0, 'h0033, 'h0000, 0, 0, 'h0000, 'h0000, 'h7777, 1, 1, 0, 0, 0, 0, 'h0033, 'h0000, 'h0A0A));
    tbl.push_back(mk(1, 1, 0, 'h0033, 'h0000, 1, 1, 'h0444, 'h0000, 'h7777, 1, 1, 0, 0, 0, 0, 'h0033, 'h0000, 'h0A0A));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0, 0, 0, 0, 1, 'h0000, 'h0000, 'h0000));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0, 0, 0, 0, 1, 'h0000, 'h0000, 'h0000));
    tbl.push_back(mk(0, 0, 0, 'h0000, 'h0000, 0, 0, 'h0000, 'h0000, 'h0000, 0, 0, 0, 0, 0, 1, 'h0000, 'h0000, 'h0000));

    reset = 1'b1;
    zero_inputs();
    @(negedge clk);

    // Directed vectors on the WAIT_STATES=2 instance: check this cycle, then drive
    for (int i = 0; i < tbl.size(); i++) begin
      string p;
      p = $sformatf("vec%0d", i);
      chk1({p, ".busy"}, busy[0], tbl[i].e_busy);
      chk1({p, ".oe"}, oe[0], tbl[i].e_oe);
      chk1({p, ".we"}, we[0], tbl[i].e_we);
      chk1({p, ".cpu_ack"}, cpu_ack[0], tbl[i].e_cack);
      chk1({p, ".ldr_ack"}, ldr_ack[0], tbl[i].e_lack);
      chk1({p, ".gnt_ldr"}, gnt_ldr[0], tbl[i].e_gnt);
      chk16({p, ".addr"}, addr[0], tbl[i].e_addr);
      chk16({p, ".dout"}, dout[0], tbl[i].e_dout);
      chk16({p, ".rdata"}, rdata[0], tbl[i].e_rdata);
      reset        = tbl[i].rst;
      cpu_req[0]   = tbl[i].cr;
      cpu_we[0]    = tbl[i].cw;
      cpu_addr[0]  = tbl[i].ca;
      cpu_wdata[0] = tbl[i].cd;
      ldr_req[0]   = tbl[i].lr;
      ldr_we[0]    = tbl[i].lw;
      ldr_addr[0]  = tbl[i].la;
      ldr_wdata[0] = tbl[i].ld;
      sram_rd[0]   = tbl[i].sd;
      @(negedge clk);
    end

    // Ack latency for WAIT_STATES = 2, 1, 7 (request seen in cycle T)
    do_reset();
    for (int g = 0; g < 3; g++) begin
      cpu_req[g] = 1'b1;
      lat[g] = 0;
    end
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if ((lat[g] == 0) && (cpu_ack[g] === 1'b1)) begin
          lat[g] = n;
          cpu_req[g] = 1'b0;
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      chki($sformatf("latency_ws%0d", ws_of(g)), lat[g], int'(ws_of(g)) + 1);
    end

    // Both requests held high: grants must alternate CPU, loader, CPU
    run_model(24, 1'b1);

    // Randomized traffic against the reference model
    run_model(400, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_sram_arbiter
